hfrv_uart_sink: RTL and testbench
=================================

// Module: hfrv_uart_sink
// PURPOSE
//  Serial receiver for the HF-RISC core's uart_tx output; sits directly downstream of the cpu modport.
//  Deserialises 8N1 frames into bytes, buffers them in a small FIFO and presents them on a valid/ready port.
//  Used by the verification environment and on-board debug logic to capture core console output.
//  Flags framing errors and FIFO overruns.
// PARAMETERS
//  CLK_DIV     434  clock cycles per bit (25 MHz / 57600 baud); legal range >= 4, even
//  FIFO_DEPTH  8    byte FIFO entries; power of two, >= 2
// PORTS
//  clk           in   1    system clock, all logic on rising edge
//  reset_n       in   1    asynchronous, active-low reset
//  uart_tx_i     in   1    serial line from cpu uart_tx; idle high, asynchronous to clk
//  byte_o        out  8    FIFO head byte
//  byte_valid_o  out  1    FIFO non-empty
//  byte_ready_i  in   1    consumer accepts byte_o when byte_valid_o && byte_ready_i
//  fifo_count_o  out  $clog2(FIFO_DEPTH+1)  occupancy
//  busy_o        out  1    FSM not in IDLE
//  frame_err_o   out  1    one-cycle pulse: stop bit sampled low
//  overrun_o     out  1    sticky: complete byte dropped because FIFO was full
//  clr_i         in   1    synchronous clear of overrun_o
// BEHAVIOUR
//  Reset (async assert): all outputs 0, FIFO empty, FSM IDLE, synchroniser flops = 1, counters 0.
//  Input: 2-flop synchroniser on uart_tx_i (line_s); all decisions use line_s. Adds 2 cycles of latency.
//  Bit timer: down-counter; a "tick" occurs when it reaches 0. Bit index counts 0..7.
//  FSM states:
//   IDLE : line_s==0 -> START, timer = CLK_DIV/2-1.
//   START: tick and line_s==0 -> DATA, timer = CLK_DIV-1, idx = 0.
//          tick and line_s==1 -> IDLE (glitch rejected, no flag).
//   DATA : tick -> shift line_s in LSB-first, timer = CLK_DIV-1.
//          idx==7 -> STOP, else idx+1.
//   STOP : tick and line_s==1 -> push byte, then IDLE. A new start edge in the same bit period is caught.
//          tick and line_s==0 -> frame_err_o pulses, byte discarded, go to BREAK.
//   BREAK: wait for line_s==1 -> IDLE (a held break yields exactly one frame_err).
//  Push happens in the mid-stop-bit cycle; byte_valid_o/fifo_count_o reflect it on the next cycle.
//  Pop happens on byte_valid_o && byte_ready_i. byte_o shows the next entry on the following cycle.
//  Full FIFO, push without pop: byte dropped, overrun_o set (stays set until clr_i or reset).
//  Full FIFO, push with pop in the same cycle: both occur, count unchanged, no overrun.
//  Empty FIFO: byte_ready_i has no effect, and byte_o holds its last value.
//  Single-entry FIFO, push with pop: count stays 1, byte_o becomes the new byte.
//  clr_i and an overrun event in the same cycle: overrun_o = 1 (set wins).
//  FIFO read/write pointers are $clog2(FIFO_DEPTH)+1 bits wide and wrap naturally.
//  Full and empty are decided by MSB comparison.
//  Reset mid-frame: partial byte discarded, no flags; after release, wait for line_s==1 before
//   a falling edge counts, via an IDLE entry condition of a registered line_s==1.
// STRUCTURE
//  Package hfrv_uart_pkg:
//   - typedef enum logic [2:0] uart_rx_state_t {IDLE, START, DATA, STOP, BREAK}
//   - localparams UART_DATA_BITS = 8, UART_IDLE_LEVEL = 1'b1
//  Sub-module hfrv_byte_fifo (WIDTH, DEPTH): sync FIFO, push/pop/full/empty/count.
//   Reused later on the transmit side.
//  Top: synchroniser, timer, FSM, shift register, flag logic.
// TESTING (bench CLK_DIV=16, FIFO_DEPTH=4)
//  1. Send 0xA5 at 16 clk/bit, ready=1
//     -> byte_o=0xA5 valid for 1 cycle, ~152 cycles after the start edge; no flags.
//  2. Low glitch of 5 cycles on idle line -> FSM returns to IDLE, no byte, no flags.
//  3. Frame 0x3C with stop bit low, line then held low for 40 cycles
//     -> exactly one frame_err_o pulse, count=0; next valid 0x11 received OK.
//  4. ready=0, send 0x01..0x05 back-to-back -> count=4, overrun_o=1, pops return 0x01..0x04.
//     clr_i clears overrun_o.
//  5. FIFO full; ready pulsed in the exact push cycle of 0x77 -> count stays 4, no overrun, 0x77 last out.
//  6. reset_n asserted after bit 3 of 0xFF, released with line high
//     -> outputs 0 immediately; next frame 0x5A received intact.

Source files
------------

// File: rtl/hfrv_uart_sink_pkg.sv
// Shared types and constants for the HF-RISC UART receive path.
package hfrv_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/hfrv_byte_fifo.sv
// Synchronous FIFO with a registered head so the output holds its last value when empty.
module hfrv_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign wr_d    = wr_q + PW'(do_push);
  assign rd_d    = rd_q + PW'(do_pop);
  assign count_o = CW'(wr_q - rd_q);
  assign rdata_o = head_q;

  // Next head bypasses the write port when the new entry becomes the head.
  always_comb begin
    head_d = head_q;
    if (wr_d != rd_d) begin
      if (do_push && (rd_d[AW-1:0] == wr_q[AW-1:0])) head_d = wdata_i;
      else                                          head_d = mem_q[rd_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/hfrv_uart_sink.sv
// 8N1 receiver for the core's uart_tx line: synchroniser, bit timer, FSM and byte FIFO.
module hfrv_uart_sink
  import hfrv_uart_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            uart_tx_i,
  output logic [UART_DATA_BITS-1:0]       byte_o,
  output logic                            byte_valid_o,
  input  logic                            byte_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_o,
  output logic                            busy_o,
  output logic                            frame_err_o,
  output logic                            overrun_o,
  input  logic                            clr_i
);
  localparam int TW = $clog2(CLK_DIV);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [TW-1:0] HALF_BIT = TW'(CLK_DIV / 2 - 1);
  localparam logic [TW-1:0] FULL_BIT = TW'(CLK_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(UART_DATA_BITS - 1);

  uart_rx_state_t            state_q, state_d;
  logic [1:0]                sync_q;
  logic                      line_s;
  logic                      armed_q;
  logic [TW-1:0]             timer_q, timer_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overrun_q, overrun_d;
  logic                      tick, push, pop, fifo_full, fifo_empty;

  assign line_s       = sync_q[1];
  assign tick         = (timer_q == '0);
  assign busy_o       = (state_q != IDLE);
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;
  assign byte_valid_o = !fifo_empty;
  assign pop          = byte_ready_i && !fifo_empty;

  always_comb begin
    state_d     = state_q;
    timer_d     = tick ? timer_q : timer_q - TW'(1);
    idx_d       = idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      // armed_q is last cycle's line level, so only a genuine falling edge starts a frame.
      IDLE: if (armed_q && line_s != UART_IDLE_LEVEL) begin
        state_d = START;
        timer_d = HALF_BIT;
      end
      START: if (tick) begin
        if (line_s != UART_IDLE_LEVEL) begin
          state_d = DATA;
          timer_d = FULL_BIT;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: if (tick) begin
        shift_d = {line_s, shift_q[UART_DATA_BITS-1:1]};
        timer_d = FULL_BIT;
        if (idx_q == LAST_IDX) state_d = STOP;
        else                   idx_d   = idx_q + IW'(1);
      end
      STOP: if (tick) begin
        if (line_s == UART_IDLE_LEVEL) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = BREAK;
        end
      end
      BREAK: if (line_s == UART_IDLE_LEVEL) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    if (push && fifo_full && !pop) overrun_d = 1'b1;
    else if (clr_i)                overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sync_q      <= {2{UART_IDLE_LEVEL}};
      armed_q     <= 1'b0;
      timer_q     <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[0], uart_tx_i};
      armed_q     <= (line_s == UART_IDLE_LEVEL);
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  hfrv_byte_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (pop),
    .rdata_o (byte_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

endmodule

// File: tb/tb_hfrv_uart_sink.sv
// Bench for hfrv_uart_sink: byte-level queue model of the FIFO fed by frame arrival times.
module tb_hfrv_uart_sink;
  localparam int CLK_DIV  = 16;
  localparam int DEPTH    = 4;
  localparam int CW       = $clog2(DEPTH + 1);
  // Line falls just after edge e: 2 sync edges + 1 to leave IDLE, half a bit, then 8 data + stop.
  localparam int PUSH_LAT = 3 + CLK_DIV / 2 + 9 * CLK_DIV;

  logic          clk = 1'b0, reset_n = 1'b0, uart_tx = 1'b1, ready = 1'b0, clr = 1'b0;
  logic [7:0]    byte_o;
  logic          byte_valid, busy, frame_err, overrun;
  logic [CW-1:0] count;

  hfrv_uart_sink #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .uart_tx_i    (uart_tx),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid),
    .byte_ready_i (ready),
    .fifo_count_o (count),
    .busy_o       (busy),
    .frame_err_o  (frame_err),
    .overrun_o    (overrun),
    .clr_i        (clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_n;
    logic [7:0] b;
    bit         good;
  } arr_t;

  int         errors = 0, checks = 0, cyc = 0;
  arr_t       arr_q[$];
  logic [7:0] mq[$];
  logic [7:0] popped[$];
  logic [7:0] last_head = 8'h00;
  bit         ovr_m = 1'b0, fe_m = 1'b0;
  bit         m_pop, m_push, m_drop;
  logic [7:0] m_b;
  int         vcount = 0, vlast = 0, fe_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: the FIFO as a queue, pushes at computed mid-stop-bit edges, pops on valid && ready.
  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      mq.delete();
      arr_q.delete();
      last_head = 8'h00;
      ovr_m     = 1'b0;
      fe_m      = 1'b0;
    end else begin
      cyc++;
      m_pop  = (mq.size() > 0) && ready;
      m_push = 1'b0;
      fe_m   = 1'b0;
      m_b    = 8'h00;
      if (arr_q.size() > 0 && arr_q[0].edge_n == cyc) begin
        m_b = arr_q[0].b;
        if (arr_q[0].good) m_push = 1'b1;
        else               fe_m   = 1'b1;
        void'(arr_q.pop_front());
      end
      if (m_pop) popped.push_back(mq.pop_front());
      m_drop = m_push && (mq.size() == DEPTH);
      if (m_push && !m_drop) mq.push_back(m_b);
      if (m_drop)   ovr_m = 1'b1;
      else if (clr) ovr_m = 1'b0;
      if (mq.size() > 0) last_head = mq[0];
    end
  end

  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      chk("valid", int'(byte_valid), int'(mq.size() > 0));
      chk("count", int'(count), mq.size());
      chk("byte", int'(byte_o), int'(mq.size() > 0 ? mq[0] : last_head));
      chk("overrun", int'(overrun), int'(ovr_m));
      chk("frame_err", int'(frame_err), int'(fe_m));
      if (byte_valid) begin vcount++; vlast = cyc; end
      if (frame_err) fe_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v);
    uart_tx = v;
    idle(CLK_DIV);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the stop bit.
  task automatic send_frame(input logic [7:0] b, input bit stop);
    arr_q.push_back('{cyc + PUSH_LAT, b, stop});
    drive(1'b0);
    for (int i = 0; i < 8; i++) drive(b[i]);
    drive(stop);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_byte"}, int'(byte_o), 0);
    chk({tag, "_valid"}, int'(byte_valid), 0);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ferr"}, int'(frame_err), 0);
    chk({tag, "_ovr"}, int'(overrun), 0);
  endtask

  function automatic int pq(input int i);
    return (popped.size() > i) ? int'(popped[i]) : -1;
  endfunction

  initial begin
    int e, v0, f0, p;
    #1 chk_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    idle(4);

    // 1: single byte, consumer always ready
    ready = 1'b1; popped.delete(); v0 = vcount; e = cyc;
    send_frame(8'hA5, 1'b1);
    idle(10);
    chk("t1_pops", popped.size(), 1);
    chk("t1_byte", pq(0), 'hA5);
    chk("t1_vcycles", vcount - v0, 1);
    chk("t1_latency", vlast - e, 155);

    // 2: 5-cycle low glitch
    f0 = fe_cnt;
    uart_tx = 1'b0; idle(5); uart_tx = 1'b1;
    chk("t2_busy_mid", int'(busy), 1);
    idle(20);
    chk("t2_busy_end", int'(busy), 0);
    chk("t2_count", int'(count), 0);
    chk("t2_ferr", fe_cnt - f0, 0);

    // 3: bad stop bit, held break, then a good frame
    ready = 1'b0; f0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    idle(40);
    uart_tx = 1'b1;
    idle(20);
    chk("t3_ferr_pulses", fe_cnt - f0, 1);
    chk("t3_count", int'(count), 0);
    send_frame(8'h11, 1'b1);
    idle(4);
    chk("t3_count2", int'(count), 1);
    chk("t3_byte", int'(byte_o), 'h11);
    popped.delete(); ready = 1'b1; idle(3);
    chk("t3_pop", pq(0), 'h11);

    // 4: overrun with consumer stalled
    ready = 1'b0; popped.delete();
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
    idle(4);
    chk("t4_count", int'(count), 4);
    chk("t4_ovr", int'(overrun), 1);
    ready = 1'b1; idle(6); ready = 1'b0;
    chk("t4_pops", popped.size(), 4);
    for (int i = 0; i < 4; i++) chk("t4_pop_byte", pq(i), i + 1);
    chk("t4_ovr_sticky", int'(overrun), 1);
    clr = 1'b1; idle(1); clr = 1'b0;
    chk("t4_ovr_clr", int'(overrun), 0);

    // 5: full FIFO, pop in the exact push cycle
    popped.delete();
    for (int b = 'h21; b <= 'h24; b++) send_frame(8'(b), 1'b1);
    idle(2);
    chk("t5_full", int'(count), 4);
    p = cyc + PUSH_LAT;
    fork
      send_frame(8'h77, 1'b1);
      begin
        while (cyc < p - 1) begin @(posedge clk); #1; end
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
      end
    join
    idle(2);
    chk("t5_count", int'(count), 4);
    chk("t5_ovr", int'(overrun), 0);
    chk("t5_pop0", pq(0), 'h21);
    chk("t5_head", int'(byte_o), 'h22);
    ready = 1'b1; idle(6);
    chk("t5_pops", popped.size(), 5);
    chk("t5_pop3", pq(3), 'h24);
    chk("t5_last", pq(4), 'h77);

    // 6: reset mid-frame after bit 3 of 0xFF
    idle(10);
    drive(1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1);
    idle(4);
    chk("t6_busy", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("t6");
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    idle(10);
    chk("t6_busy_after", int'(busy), 0);
    chk("t6_count", int'(count), 0);
    popped.delete();
    send_frame(8'h5A, 1'b1);
    idle(10);
    chk("t6_pops", popped.size(), 1);
    chk("t6_byte", pq(0), 'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
